sc_and_acc: RTL

- Stochastic-to-binary stage directly downstream of the stochastic bit-stream generator.
- Each cycle of a generation window it multiplies 4 activation stream bits by 4 weight stream bits (bitwise AND), popcounts the products (0..4) and accumulates over the window.
- At window end it emits the binary dot-product count with a one-cycle valid pulse, for the next layer or readout.

---
 rtl/sc_pkg.sv | 26 ++
 rtl/sc_popcnt4.sv | 18 +
 rtl/sc_and_acc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic AND-accumulate stage.
// The optional quantizer is enabled with SC_ACC_QUANT_EN.
package sc_pkg;

  localparam int unsigned SC_N_IN    = 4;
  localparam int unsigned SC_WIN_MAX = 16;
  localparam int unsigned SC_ACC_W   = 7;
  localparam int unsigned SC_Q_W     = 4;
  localparam int unsigned SC_PC_W    = 3;
  localparam int unsigned SC_LEN_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } sc_acc_state_e;

  // Divide the window count by 4 and saturate to the next layer's 4-bit input range.
  function automatic logic [SC_Q_W-1:0] sc_quantize(input logic [SC_ACC_W-1:0] sum);
    logic [SC_ACC_W-3:0] sh;
    sh = sum[SC_ACC_W-1:2];
    if (sh > (SC_ACC_W-2)'(15)) return SC_Q_W'(15);
    else                        return SC_Q_W'(sh);
  endfunction

endpackage

// File: rtl/sc_popcnt4.sv
// Stochastic multiply (bitwise AND) of four lane pairs followed by a popcount.
module sc_popcnt4
  import sc_pkg::*;
(
  input  logic [SC_N_IN-1:0] i_a,
  input  logic [SC_N_IN-1:0] i_b,
  output logic [SC_PC_W-1:0] o_cnt_c
);

  logic [SC_N_IN-1:0] prod;

  always_comb begin
    prod    = i_a & i_b;
    o_cnt_c = SC_PC_W'(prod[0]) + SC_PC_W'(prod[1])
            + SC_PC_W'(prod[2]) + SC_PC_W'(prod[3]);
  end

endmodule

// File: rtl/sc_and_acc.sv
// Window accumulator turning AND-ed stochastic streams into a binary dot-product count.
// Optional output quantizer is built when SC_ACC_QUANT_EN is defined.
module sc_and_acc
  import sc_pkg::*;
(
  input  logic                i_clk_sc_acc,
  input  logic                i_rst_sc_acc,
  input  logic                i_isgen,
  input  logic                i_sn_bit [SC_N_IN-1:0],
  input  logic                i_wn_bit [SC_N_IN-1:0],
  output logic [SC_ACC_W-1:0] o_sum,
  output logic [SC_LEN_W-1:0] o_len,
  output logic                o_valid,
  output logic                o_ovf,
  output logic                o_busy,
  output logic [SC_Q_W-1:0]   o_q
);

  sc_acc_state_e       state_q, state_d;
  logic [SC_ACC_W-1:0] acc_q, acc_d;
  logic [SC_LEN_W-1:0] cnt_q, cnt_d;
  logic [SC_ACC_W-1:0] sum_q, sum_d;
  logic [SC_LEN_W-1:0] len_q, len_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic [SC_N_IN-1:0]  sn_vec, wn_vec;
  logic [SC_PC_W-1:0]  pc_c;

  always_comb begin
    for (int k = 0; k < SC_N_IN; k++) begin
      sn_vec[k] = i_sn_bit[k];
      wn_vec[k] = i_wn_bit[k];
    end
  end

  sc_popcnt4 u_popcnt (
    .i_a     (sn_vec),
    .i_b     (wn_vec),
    .o_cnt_c (pc_c)
  );

  // Next-state, accumulator and result capture.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_isgen) begin
          state_d = ACC;
          acc_d   = SC_ACC_W'(pc_c);
          cnt_d   = SC_LEN_W'(1);
        end
      end
      ACC: begin
        if (!i_isgen) begin
          sum_d   = acc_q;
          len_d   = cnt_q;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q < SC_LEN_W'(SC_WIN_MAX)) begin
          acc_d = acc_q + SC_ACC_W'(pc_c);
          cnt_d = cnt_q + SC_LEN_W'(1);
        end else begin
          // Window cut at its limit: this cycle's bits are dropped.
          sum_d   = acc_q;
          len_d   = SC_LEN_W'(SC_WIN_MAX);
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_isgen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_sc_acc or posedge i_rst_sc_acc) begin
    if (i_rst_sc_acc) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_len   = len_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = busy_q;

`ifdef SC_ACC_QUANT_EN
  logic [SC_Q_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (valid_d) q_d = sc_quantize(sum_d);
  end

  always_ff @(posedge i_clk_sc_acc or posedge i_rst_sc_acc) begin
    if (i_rst_sc_acc) q_q <= '0;
    else              q_q <= q_d;
  end

  assign o_q = q_q;
`else
  assign o_q = '0;
`endif

endmodule
